// File: rtl/sha3_block_feeder_pkg.sv
// rtl/sha3_block_feeder_pkg.sv - shared constants and types for the SHA3 rate-block feeder
// Purpose: rate geometry, default pad bytes and feeder state encoding.
// Ports: none (package).
package sha3_block_feeder_pkg;

   localparam int RATE_BYTES       = 136;
   localparam int RATE_W           = RATE_BYTES * 8;
   localparam int CHUNK_W          = 136;
   localparam int CHUNKS_PER_BLOCK = 8;
   localparam int WORDS_PER_BLOCK  = 17;

   localparam logic [7:0] DOMAIN_PAD_BYTE = 8'h06;
   localparam logic [7:0] FINAL_PAD_BYTE  = 8'h80;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      SEND = 2'd1,
      PAD  = 2'd2
   } feeder_state_e;

endpackage

// File: rtl/sha3_block_feeder_if.sv
// rtl/sha3_block_feeder_if.sv - message-word input and scan-chunk output bundle
// Purpose: groups the message word stream and the 136-bit chunk stream.
// Ports (signals): in_valid/in_ready/in_data/in_last/in_bytes (message words),
//   chunk_valid/chunk_ready/chunk_data/chunk_idx/msg_last (chunk stream), block_done (pulse).
// Modports: slave = the feeder, master = the environment around it.
interface sha3_block_feeder_if;

   logic                                   in_valid;
   logic                                   in_ready;
   logic [63:0]                            in_data;
   logic                                   in_last;
   logic [3:0]                             in_bytes;
   logic                                   chunk_valid;
   logic                                   chunk_ready;
   logic [sha3_block_feeder_pkg::CHUNK_W-1:0] chunk_data;
   logic [2:0]                             chunk_idx;
   logic                                   msg_last;
   logic                                   block_done;

   modport master (
      output in_valid, in_data, in_last, in_bytes, chunk_ready,
      input  in_ready, chunk_valid, chunk_data, chunk_idx, msg_last, block_done
   );

   modport slave (
      input  in_valid, in_data, in_last, in_bytes, chunk_ready,
      output in_ready, chunk_valid, chunk_data, chunk_idx, msg_last, block_done
   );

endinterface

// File: rtl/sha3_pad_merge.sv
// rtl/sha3_pad_merge.sv - byte enables and padded lane values for one message word
// Purpose: places a 64-bit word at word_cnt in the rate block and, on the last word,
//   adds the domain byte at byte p and the final pad bit at byte 135 when p < 136.
// Ports: word, in_bytes, last, word_cnt in; byte_en (136), byte_val (1088), pos, pad_fits out.
module sha3_pad_merge
   import sha3_block_feeder_pkg::*;
#(
   parameter logic [7:0] DOMAIN_PAD = DOMAIN_PAD_BYTE,
   parameter logic [7:0] FINAL_PAD  = FINAL_PAD_BYTE
) (
   input  logic [63:0]          word,
   input  logic [3:0]           in_bytes,
   input  logic                 last,
   input  logic [4:0]           word_cnt,
   output logic [RATE_BYTES-1:0] byte_en,
   output logic [RATE_W-1:0]    byte_val,
   output logic [7:0]           pos,
   output logic                 pad_fits
);

   logic [3:0] nbytes;
   logic [7:0] base;
   logic [7:0] kb;
   logic [7:0] off;

   always_comb begin
      // Only the last word may be short; oversize counts saturate at a full word.
      nbytes = 4'd8;
      if (last && (in_bytes < 4'd8)) nbytes = in_bytes;
      base     = {word_cnt, 3'b000};
      pos      = base + {4'b0000, nbytes};
      pad_fits = last && (pos < 8'(RATE_BYTES));
      byte_en  = '0;
      byte_val = '0;
      kb       = '0;
      off      = '0;
      for (int k = 0; k < RATE_BYTES; k++) begin
         kb  = 8'(k);
         off = kb - base;
         if ((kb >= base) && (off < {4'b0000, nbytes})) begin
            byte_en[k]          = 1'b1;
            byte_val[8*k +: 8]  = word[{off[2:0], 3'b000} +: 8];
         end
         // Both pad bytes OR together so p = 135 yields DOMAIN_PAD | FINAL_PAD.
         if (pad_fits && (kb == pos)) begin
            byte_en[k]          = 1'b1;
            byte_val[8*k +: 8]  = byte_val[8*k +: 8] | DOMAIN_PAD;
         end
         if (pad_fits && (k == RATE_BYTES - 1)) begin
            byte_en[k]          = 1'b1;
            byte_val[8*k +: 8]  = byte_val[8*k +: 8] | FINAL_PAD;
         end
      end
   end

endmodule

// File: rtl/sha3_block_feeder.sv
// rtl/sha3_block_feeder.sv - pads a 64-bit word message and emits 1088-bit blocks as 8 chunks
// Purpose: FILL collects 17 words per block, SEND streams 8 x 136-bit chunks,
//   PAD builds the extra pad-only block when the message ends on a block boundary.
// Ports: clk, reset (sync, active-high), bus (slave modport: message words in, chunks out,
//   msg_last marks the final block, block_done pulses after chunk 7 handshakes).
module sha3_block_feeder
   import sha3_block_feeder_pkg::*;
#(
   parameter logic [7:0] DOMAIN_PAD = DOMAIN_PAD_BYTE,
   parameter logic [7:0] FINAL_PAD  = FINAL_PAD_BYTE
) (
   input  logic               clk,
   input  logic               reset,
   sha3_block_feeder_if.slave bus
);

   feeder_state_e       state_q, state_d;
   logic [4:0]          word_cnt_q, word_cnt_d;
   logic [RATE_W-1:0]   buf_q, buf_d;
   logic                final_q, final_d;
   logic                pad_pending_q, pad_pending_d;
   logic [2:0]          chunk_idx_q, chunk_idx_d;
   logic                block_done_q, block_done_d;

   logic [RATE_BYTES-1:0] byte_en;
   logic [RATE_W-1:0]     byte_val;
   logic [RATE_W-1:0]     bit_mask;
   logic [7:0]            pos;
   logic                  pad_fits;
   logic                  in_hs;
   logic                  out_hs;

   sha3_pad_merge #(
      .DOMAIN_PAD (DOMAIN_PAD),
      .FINAL_PAD  (FINAL_PAD)
   ) u_pad_merge (
      .word     (bus.in_data),
      .in_bytes (bus.in_bytes),
      .last     (bus.in_last),
      .word_cnt (word_cnt_q),
      .byte_en  (byte_en),
      .byte_val (byte_val),
      .pos      (pos),
      .pad_fits (pad_fits)
   );

   always_comb begin
      bit_mask = '0;
      for (int k = 0; k < RATE_BYTES; k++) begin
         bit_mask[8*k +: 8] = {8{byte_en[k]}};
      end
   end

   assign in_hs  = (state_q == FILL) && bus.in_valid;
   assign out_hs = (state_q == SEND) && bus.chunk_ready;

   always_comb begin
      state_d       = state_q;
      word_cnt_d    = word_cnt_q;
      buf_d         = buf_q;
      final_d       = final_q;
      pad_pending_d = pad_pending_q;
      chunk_idx_d   = chunk_idx_q;
      block_done_d  = 1'b0;
      case (state_q)
         FILL: begin
            if (in_hs) begin
               buf_d      = (buf_q & ~bit_mask) | byte_val;
               word_cnt_d = word_cnt_q + 5'd1;
               if (bus.in_last) begin
                  state_d = SEND;
                  if (pad_fits) begin
                     final_d = 1'b1;
                  end else begin
                     // Message filled the block exactly: padding goes in a block of its own.
                     final_d       = 1'b0;
                     pad_pending_d = 1'b1;
                  end
               end else if (word_cnt_q == 5'(WORDS_PER_BLOCK - 1)) begin
                  state_d = SEND;
                  final_d = 1'b0;
               end
            end
         end
         SEND: begin
            if (out_hs) begin
               chunk_idx_d = chunk_idx_q + 3'd1;
               if (chunk_idx_q == 3'(CHUNKS_PER_BLOCK - 1)) begin
                  block_done_d = 1'b1;
                  word_cnt_d   = '0;
                  buf_d        = '0;
                  final_d      = 1'b0;
                  state_d      = pad_pending_q ? PAD : FILL;
               end
            end
         end
         PAD: begin
            buf_d                 = '0;
            buf_d[7:0]            = DOMAIN_PAD;
            buf_d[RATE_W-1 -: 8]  = FINAL_PAD;
            final_d               = 1'b1;
            pad_pending_d         = 1'b0;
            state_d               = SEND;
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FILL;
         word_cnt_q    <= '0;
         buf_q         <= '0;
         final_q       <= 1'b0;
         pad_pending_q <= 1'b0;
         chunk_idx_q   <= '0;
         block_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         buf_q         <= buf_d;
         final_q       <= final_d;
         pad_pending_q <= pad_pending_d;
         chunk_idx_q   <= chunk_idx_d;
         block_done_q  <= block_done_d;
      end
   end

   assign bus.in_ready    = (state_q == FILL);
   assign bus.chunk_valid = (state_q == SEND);
   assign bus.chunk_data  = buf_q[chunk_idx_q * CHUNK_W +: CHUNK_W];
   assign bus.chunk_idx   = chunk_idx_q;
   assign bus.msg_last    = final_q;
   assign bus.block_done  = block_done_q;

endmodule
